// File: rtl/snake_head_mover.sv
// snake_head_mover: IDLE/RUN/DEAD head-position engine for a tile-based snake game.
// Optional macro SNAKE_WALL_WRAP_EN: wrap at the grid edges instead of dying there.
`default_nettype none

module snake_head_mover #(
   parameter int STEP_CYCLES = 12500000,
   parameter int GRID_W      = 20,
   parameter int GRID_H      = 15,
   parameter int INIT_X      = 1,
   parameter int INIT_Y      = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        dir_valid,
   input  logic [1:0]  dir_req,
   input  logic [4:0]  apple_x,
   input  logic [3:0]  apple_y,
   input  logic        body_hit,
   input  logic [31:0] pxl_x,
   input  logic [31:0] pxl_y,
   output logic [4:0]  head_x,
   output logic [3:0]  head_y,
   output logic        step,
   output logic        apple_eaten,
   output logic        draw_head,
   output logic        gameover,
   output logic        running
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DEAD = 2'd2;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   localparam int            CW       = $clog2(STEP_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);
   localparam logic [4:0]    X_MAX    = 5'(GRID_W - 1);
   localparam logic [3:0]    Y_MAX    = 4'(GRID_H - 1);
   localparam logic [4:0]    X_INIT   = 5'(INIT_X);
   localparam logic [3:0]    Y_INIT   = 4'(INIT_Y);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [1:0]    cur_dir;
   logic [1:0]    pend_dir;
   logic [4:0]    next_x;
   logic [3:0]    next_y;
   logic          wall_kill;
   logic          dir_ok;
   logic          cnt_wrap;

   // Opposite directions differ only in the MSB of the 2-bit encoding.
   assign dir_ok   = dir_valid && (dir_req != (cur_dir ^ 2'b10));
   assign cnt_wrap = (cnt == CNT_LAST);
   assign running  = (state == S_RUN);
   assign gameover = (state == S_DEAD);

   // The move is taken from the pending direction, which becomes committed on the same edge.
   always_comb begin
      next_x    = head_x;
      next_y    = head_y;
      wall_kill = 1'b0;
      case (pend_dir)
         DIR_UP: begin
            if (head_y == 4'd0) begin
`ifdef SNAKE_WALL_WRAP_EN
               next_y = Y_MAX;
`else
               wall_kill = 1'b1;
`endif
            end else begin
               next_y = head_y - 4'd1;
            end
         end
         DIR_RIGHT: begin
            if (head_x == X_MAX) begin
`ifdef SNAKE_WALL_WRAP_EN
               next_x = 5'd0;
`else
               wall_kill = 1'b1;
`endif
            end else begin
               next_x = head_x + 5'd1;
            end
         end
         DIR_DOWN: begin
            if (head_y == Y_MAX) begin
`ifdef SNAKE_WALL_WRAP_EN
               next_y = 4'd0;
`else
               wall_kill = 1'b1;
`endif
            end else begin
               next_y = head_y + 4'd1;
            end
         end
         default: begin
            if (head_x == 5'd0) begin
`ifdef SNAKE_WALL_WRAP_EN
               next_x = X_MAX;
`else
               wall_kill = 1'b1;
`endif
            end else begin
               next_x = head_x - 5'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         head_x      <= X_INIT;
         head_y      <= Y_INIT;
         cur_dir     <= DIR_RIGHT;
         pend_dir    <= DIR_RIGHT;
         step        <= 1'b0;
         apple_eaten <= 1'b0;
         draw_head   <= 1'b0;
      end else begin
         step        <= 1'b0;
         apple_eaten <= 1'b0;
         draw_head   <= ((pxl_x >> 5) == {27'b0, head_x}) &&
                        ((pxl_y >> 5) == {28'b0, head_y});
         if (dir_ok) begin
            pend_dir <= dir_req;
         end
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (start) begin
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (body_hit) begin
                  state <= S_DEAD;
                  cnt   <= '0;
               end else if (cnt_wrap) begin
                  cnt     <= '0;
                  cur_dir <= pend_dir;
                  if (wall_kill) begin
                     state <= S_DEAD;
                  end else begin
                     head_x      <= next_x;
                     head_y      <= next_y;
                     step        <= 1'b1;
                     apple_eaten <= (next_x == apple_x) && (next_y == apple_y);
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DEAD: begin
               cnt <= '0;
               if (start) begin
                  state    <= S_IDLE;
                  head_x   <= X_INIT;
                  head_y   <= Y_INIT;
                  cur_dir  <= DIR_RIGHT;
                  pend_dir <= DIR_RIGHT;
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_snake_head_mover.sv
// tb_snake_head_mover: directed-vector bench for snake_head_mover with STEP_CYCLES=4.
`default_nettype none

module tb_snake_head_mover;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        dir_valid;
   logic [1:0]  dir_req;
   logic [4:0]  apple_x;
   logic [3:0]  apple_y;
   logic        body_hit;
   logic [31:0] pxl_x;
   logic [31:0] pxl_y;
   logic [4:0]  head_x;
   logic [3:0]  head_y;
   logic        step;
   logic        apple_eaten;
   logic        draw_head;
   logic        gameover;
   logic        running;

   int vectors = 0;
   int errors  = 0;

   snake_head_mover #(
      .STEP_CYCLES(4),
      .GRID_W     (20),
      .GRID_H     (15),
      .INIT_X     (1),
      .INIT_Y     (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .dir_valid  (dir_valid),
      .dir_req    (dir_req),
      .apple_x    (apple_x),
      .apple_y    (apple_y),
      .body_hit   (body_hit),
      .pxl_x      (pxl_x),
      .pxl_y      (pxl_y),
      .head_x     (head_x),
      .head_y     (head_y),
      .step       (step),
      .apple_eaten(apple_eaten),
      .draw_head  (draw_head),
      .gameover   (gameover),
      .running    (running)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; dir_valid = 1'b0; dir_req = 2'b00;
      apple_x = 5'd3; apple_y = 4'd1; body_hit = 1'b0; pxl_x = 32'd0; pxl_y = 32'd0;
      tick(); tick();
      reset = 1'b0;
      vectors++;
      if (head_x !== 5'd1 || head_y !== 4'd1) begin
         errors++;
         $display("FAIL reset_head: got (%0d,%0d) expected (1,1)", head_x, head_y);
      end
      vectors++;
      if ({running, gameover, step, apple_eaten, draw_head} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_flags: got run/go/step/eat/draw=%b expected 00000",
                  {running, gameover, step, apple_eaten, draw_head});
      end
   endtask

   // Start, ignore an opposite request, two right steps, apple at (3,1).
   task automatic test_start_steps();
      logic [4:0] ex;
      logic       early;
      ex = 5'd1;
      start = 1'b1; tick(); start = 1'b0;
      vectors++;
      if (running !== 1'b1 || gameover !== 1'b0) begin
         errors++;
         $display("FAIL start_running: got running=%b gameover=%b expected 1 0", running, gameover);
      end
      for (int s = 1; s <= 2; s++) begin
         early = 1'b0;
         for (int k = 1; k <= 4; k++) begin
            if (s == 1 && k == 1) begin dir_valid = 1'b1; dir_req = 2'b11; end
            tick();
            dir_valid = 1'b0;
            if (k < 4 && (step !== 1'b0 || apple_eaten !== 1'b0)) early = 1'b1;
         end
         ex = ex + 5'd1;
         vectors++;
         if (early || step !== 1'b1 || head_x !== ex || head_y !== 4'd1 ||
             apple_eaten !== (ex == 5'd3)) begin
            errors++;
            $display("FAIL step_right_%0d: got head=(%0d,%0d) step=%b eat=%b early=%b expected (%0d,1) step=1 eat=%b early=0",
                     s, head_x, head_y, step, apple_eaten, early, ex, (ex == 5'd3));
         end
      end
      tick();
      vectors++;
      if (step !== 1'b0 || apple_eaten !== 1'b0) begin
         errors++;
         $display("FAIL pulse_width: got step=%b eat=%b expected 0 0", step, apple_eaten);
      end
   endtask

   task automatic test_turn_down();
      dir_valid = 1'b1; dir_req = 2'b10; tick(); dir_valid = 1'b0;
      tick();
      vectors++;
      if (step !== 1'b0) begin
         errors++;
         $display("FAIL turn_no_early_step: got step=%b expected 0", step);
      end
      tick();
      vectors++;
      if (step !== 1'b1 || head_x !== 5'd3 || head_y !== 4'd2 || apple_eaten !== 1'b0) begin
         errors++;
         $display("FAIL turn_down: got head=(%0d,%0d) step=%b eat=%b expected (3,2) step=1 eat=0",
                  head_x, head_y, step, apple_eaten);
      end
   endtask

   task automatic test_draw();
      pxl_x = 32'd96; pxl_y = 32'd64; tick();
      vectors++;
      if (draw_head !== 1'b1) begin
         errors++;
         $display("FAIL draw_low_corner: got %b expected 1", draw_head);
      end
      pxl_x = 32'd127; pxl_y = 32'd95; tick();
      vectors++;
      if (draw_head !== 1'b1) begin
         errors++;
         $display("FAIL draw_high_corner: got %b expected 1", draw_head);
      end
      pxl_x = 32'd128; pxl_y = 32'd64; tick();
      vectors++;
      if (draw_head !== 1'b0) begin
         errors++;
         $display("FAIL draw_outside: got %b expected 0", draw_head);
      end
      pxl_x = 32'd0; pxl_y = 32'd0;
   endtask

   // The step counter is at its last value here, so this edge is a step edge.
   task automatic test_body_hit();
      logic bad;
      body_hit = 1'b1; tick(); body_hit = 1'b0;
      vectors++;
      if (gameover !== 1'b1 || running !== 1'b0 || step !== 1'b0 || apple_eaten !== 1'b0 ||
          head_x !== 5'd3 || head_y !== 4'd2) begin
         errors++;
         $display("FAIL body_hit_dead: got go=%b run=%b step=%b eat=%b head=(%0d,%0d) expected 1 0 0 0 (3,2)",
                  gameover, running, step, apple_eaten, head_x, head_y);
      end
      bad = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (step !== 1'b0 || head_x !== 5'd3 || head_y !== 4'd2 || gameover !== 1'b1) bad = 1'b1;
      end
      vectors++;
      if (bad) begin
         errors++;
         $display("FAIL dead_hold: got head=(%0d,%0d) go=%b expected (3,2) held, go=1", head_x, head_y, gameover);
      end
      start = 1'b1; tick(); start = 1'b0;
      vectors++;
      if (gameover !== 1'b0 || running !== 1'b0 || head_x !== 5'd1 || head_y !== 4'd1) begin
         errors++;
         $display("FAIL rearm_idle: got go=%b run=%b head=(%0d,%0d) expected 0 0 (1,1)",
                  gameover, running, head_x, head_y);
      end
      body_hit = 1'b1; tick(); body_hit = 1'b0; tick();
      vectors++;
      if (gameover !== 1'b0 || running !== 1'b0) begin
         errors++;
         $display("FAIL idle_ignores_body_hit: got go=%b run=%b expected 0 0", gameover, running);
      end
   endtask

   // Walk to (19,5) with apple at (10,5), then attempt to step off the right edge.
   task automatic test_wall();
      logic [4:0] ex;
      logic [3:0] ey;
      logic       early;
      ex = 5'd1; ey = 4'd1;
      apple_x = 5'd10; apple_y = 4'd5;
      start = 1'b1; tick(); start = 1'b0;
      for (int s = 1; s <= 22; s++) begin
         early = 1'b0;
         for (int k = 1; k <= 4; k++) begin
            if (k == 1 && s == 1) begin dir_valid = 1'b1; dir_req = 2'b10; end
            if (k == 1 && s == 5) begin dir_valid = 1'b1; dir_req = 2'b01; end
            tick();
            dir_valid = 1'b0;
            if (k < 4 && step !== 1'b0) early = 1'b1;
         end
         if (s <= 4) ey = ey + 4'd1;
         else        ex = ex + 5'd1;
         vectors++;
         if (early || step !== 1'b1 || head_x !== ex || head_y !== ey ||
             apple_eaten !== (ex == 5'd10 && ey == 4'd5)) begin
            errors++;
            $display("FAIL walk_step_%0d: got head=(%0d,%0d) step=%b eat=%b early=%b expected (%0d,%0d) step=1 eat=%b",
                     s, head_x, head_y, step, apple_eaten, early, ex, ey, (ex == 5'd10 && ey == 4'd5));
         end
      end
      tick(); tick(); tick(); tick();
`ifdef SNAKE_WALL_WRAP_EN
      vectors++;
      if (step !== 1'b1 || head_x !== 5'd0 || head_y !== 4'd5 || running !== 1'b1 || gameover !== 1'b0) begin
         errors++;
         $display("FAIL wall_wrap: got head=(%0d,%0d) step=%b run=%b go=%b expected (0,5) 1 1 0",
                  head_x, head_y, step, running, gameover);
      end
`else
      vectors++;
      if (step !== 1'b0 || head_x !== 5'd19 || head_y !== 4'd5 || running !== 1'b0 || gameover !== 1'b1) begin
         errors++;
         $display("FAIL wall_death: got head=(%0d,%0d) step=%b run=%b go=%b expected (19,5) 0 0 1",
                  head_x, head_y, step, running, gameover);
      end
`endif
   endtask

   task automatic test_reset_mid_run();
      logic early;
      apple_x = 5'd3; apple_y = 4'd1;
      reset = 1'b1; tick(); reset = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      vectors++;
      if (head_x !== 5'd2 || running !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_move: got head_x=%0d run=%b expected 2 1", head_x, running);
      end
      reset = 1'b1; start = 1'b1; body_hit = 1'b1; tick();
      reset = 1'b0; start = 1'b0; body_hit = 1'b0;
      vectors++;
      if (head_x !== 5'd1 || head_y !== 4'd1 || running !== 1'b0 || gameover !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_run: got head=(%0d,%0d) run=%b go=%b expected (1,1) 0 0",
                  head_x, head_y, running, gameover);
      end
      start = 1'b1; tick(); start = 1'b0;
      early = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         if (step !== 1'b0) early = 1'b1;
      end
      tick();
      vectors++;
      if (early || step !== 1'b1 || head_x !== 5'd2 || head_y !== 4'd1) begin
         errors++;
         $display("FAIL counter_cleared: got head=(%0d,%0d) step=%b early=%b expected (2,1) 1 0",
                  head_x, head_y, step, early);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_start_steps();
      test_turn_down();
      test_draw();
      test_body_hit();
      test_wall();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire
